// File: rtl/cfg_loader_pkg.sv
// Shared types and constants for the configuration bitstream loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCheck,
    StFinish
  } state_e;

  localparam logic [7:0] CrcPoly = 8'h07;
  localparam logic [7:0] CrcInit = 8'h00;

endpackage

// File: rtl/cfg_crc8.sv
// Serial CRC-8 over the shifted chain bits, register updated MSB-first.
module cfg_crc8
  import cfg_loader_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ bit_in;
    crc_d = crc_q;
    if (clear) begin
      crc_d = CrcInit;
    end else if (bit_en) begin
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CrcPoly : 8'h00);
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cfg_stream_loader.sv
// Streams host bitstream words LSB-first into a configuration scan chain.
// Define CFG_CRC_EN to add the trailing CRC-8 check word (CHECK state, crc_err).
module cfg_stream_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  bit_count,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              chain_data,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              crc_err
);

  localparam int unsigned FillW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [FillW-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  remain_q, remain_d;
  logic              zero_done_q, zero_done_d;
  logic              aborted_q, aborted_d;
  logic              last_shift, accept, abort_hit;

`ifdef CFG_CRC_EN
  logic [7:0] crc;
  logic       crc_clear;
  logic       crc_err_q, crc_err_d;

  cfg_crc8 u_crc (
    .clk    (prog_clk),
    .clear  (crc_clear),
    .bit_en (chain_en),
    .bit_in (buf_q[0]),
    .crc    (crc)
  );
`endif

  // Handshake and shift enables; abort masks both in the same cycle.
  always_comb begin
    chain_en   = (state_q == StLoad) && (fill_q != '0) && !abort;
    last_shift = chain_en && (remain_q == CNT_W'(1));
    wr_ready   = 1'b0;
    if (state_q == StLoad) begin
      // Refill during the last buffered bit, unless that bit ends the load.
      wr_ready = !abort && ((fill_q == '0) ||
                            (chain_en && (fill_q == FillW'(1)) && !last_shift));
    end
`ifdef CFG_CRC_EN
    else if (state_q == StCheck) begin
      wr_ready = !abort;
    end
`endif
    accept    = wr_valid && wr_ready;
    abort_hit = abort && ((state_q == StLoad) || (state_q == StCheck));
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;
    aborted_d   = 1'b0;
`ifdef CFG_CRC_EN
    crc_clear   = !prog_rst_n;
    crc_err_d   = crc_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
`ifdef CFG_CRC_EN
          crc_clear = 1'b1;
          crc_err_d = 1'b0;
`endif
          if (bit_count != '0) begin
            remain_d = bit_count;
            state_d  = StLoad;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (chain_en) begin
          buf_d    = buf_q >> 1;
          fill_d   = fill_q - FillW'(1);
          remain_d = remain_q - CNT_W'(1);
        end
        if (accept) begin
          buf_d  = wr_data;
          fill_d = FillW'(WORD_W);
        end
        if (last_shift) begin
          buf_d  = '0;
          fill_d = '0;
`ifdef CFG_CRC_EN
          state_d = StCheck;
`else
          state_d = StFinish;
`endif
        end
      end
`ifdef CFG_CRC_EN
      StCheck: begin
        if (accept) begin
          if (wr_data[7:0] != crc) begin
            crc_err_d = 1'b1;
          end
          state_d = StFinish;
        end
      end
`endif
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort_hit) begin
      state_d   = StIdle;
      buf_d     = '0;
      fill_d    = '0;
      remain_d  = '0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      fill_q      <= '0;
      remain_q    <= '0;
      zero_done_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      remain_q    <= remain_d;
      zero_done_q <= zero_done_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef CFG_CRC_EN
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      crc_err_q <= 1'b0;
    end else begin
      crc_err_q <= crc_err_d;
    end
  end
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign chain_data = buf_q[0];
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFinish) || zero_done_q;
  assign aborted    = aborted_q;

endmodule
